// File: rtl/lfsr_bist_sequencer.sv
// Self-test sequencer for an LFSR generator/checker pair: seed load, lock acquisition,
// locked run window and optional single-bit corruption check, with pass/fail reporting.
module lfsr_bist_sequencer #(
  parameter int unsigned NB_SEED        = 8,
  parameter int unsigned NB_TMR         = 16,
  parameter int unsigned LOCK_TIMEOUT   = 64,
  parameter int unsigned RUN_CYCLES     = 256,
  parameter int unsigned UNLOCK_TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_SEED-1:0] i_seed,
  input  logic               i_inject_en,
  input  logic               i_lock,
  output logic               o_valid,
  output logic               o_soft_reset,
  output logic [NB_SEED-1:0] o_seed,
  output logic               o_corrupt,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [1:0]         o_fail_code,
  output logic [NB_TMR-1:0]  o_lock_lat
);

  typedef enum logic [2:0] {
    StIdle, StSeed, StAcquire, StRun, StInject, StWaitUnlock, StDone
  } state_e;

  localparam logic [NB_TMR-1:0] LockLast   = NB_TMR'(LOCK_TIMEOUT - 1);
  localparam logic [NB_TMR-1:0] RunLast    = NB_TMR'(RUN_CYCLES - 1);
  localparam logic [NB_TMR-1:0] UnlockLast = NB_TMR'(UNLOCK_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [NB_TMR-1:0]    timer_q, timer_d, timer_inc;
  logic [NB_SEED-1:0]   seed_d;
  logic                 pass_d;
  logic [1:0]           code_d;
  logic [NB_TMR-1:0]    lat_d;

  // Saturating increment so a huge timeout never wraps back into range.
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + NB_TMR'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    seed_d  = o_seed;
    pass_d  = o_pass;
    code_d  = o_fail_code;
    lat_d   = o_lock_lat;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StSeed;
          // An all-zero seed would lock the LFSR up, so substitute 1.
          seed_d  = (i_seed == '0) ? NB_SEED'(1) : i_seed;
          pass_d  = 1'b0;
          code_d  = 2'd0;
          lat_d   = '0;
        end
      end
      StSeed: begin
        state_d = StAcquire;
        timer_d = '0;
      end
      StAcquire: begin
        if (i_lock) begin
          state_d = StRun;
          lat_d   = timer_q;
          timer_d = '0;
        end else if (timer_q == LockLast) begin
          state_d = StDone;
          code_d  = 2'd1;
        end else begin
          timer_d = timer_inc;
        end
      end
      StRun: begin
        if (!i_lock) begin
          state_d = StDone;
          code_d  = 2'd2;
        end else if (timer_q == RunLast) begin
          if (i_inject_en) begin
            state_d = StInject;
          end else begin
            state_d = StDone;
            pass_d  = 1'b1;
          end
        end else begin
          timer_d = timer_inc;
        end
      end
      StInject: begin
        state_d = StWaitUnlock;
        timer_d = '0;
      end
      StWaitUnlock: begin
        if (!i_lock) begin
          state_d = StDone;
          pass_d  = 1'b1;
        end else if (timer_q == UnlockLast) begin
          state_d = StDone;
          code_d  = 2'd3;
        end else begin
          timer_d = timer_inc;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      o_seed       <= '0;
      o_pass       <= 1'b0;
      o_fail_code  <= 2'd0;
      o_lock_lat   <= '0;
      o_valid      <= 1'b0;
      o_soft_reset <= 1'b0;
      o_corrupt    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      o_seed       <= seed_d;
      o_pass       <= pass_d;
      o_fail_code  <= code_d;
      o_lock_lat   <= lat_d;
      o_valid      <= state_d inside {StAcquire, StRun, StInject, StWaitUnlock};
      o_soft_reset <= (state_d == StSeed);
      o_corrupt    <= (state_d == StInject);
      o_busy       <= (state_d != StIdle);
      o_done       <= (state_d == StDone);
    end
  end

endmodule

// File: tb/tb_lfsr_bist_sequencer.sv
// Directed bench for lfsr_bist_sequencer; expected test results are queued at start and
// compared when o_done pulses.
module tb_lfsr_bist_sequencer;

  localparam int NB_SEED        = 8;
  localparam int NB_TMR         = 16;
  localparam int LOCK_TIMEOUT   = 64;
  localparam int RUN_CYCLES     = 256;
  localparam int UNLOCK_TIMEOUT = 32;

  logic               clk = 1'b0;
  logic               i_rst, i_start, i_inject_en, i_lock;
  logic [NB_SEED-1:0] i_seed;
  logic               o_valid, o_soft_reset, o_corrupt, o_busy, o_done, o_pass;
  logic [NB_SEED-1:0] o_seed;
  logic [1:0]         o_fail_code;
  logic [NB_TMR-1:0]  o_lock_lat;

  typedef struct {
    logic        pass;
    logic [1:0]  code;
    logic [15:0] lat;
    logic        chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sr_cnt   = 0;
  int   cor_cnt  = 0;
  int   done_cnt = 0;
  int   sr0, cor0, cyc;

  lfsr_bist_sequencer #(
    .NB_SEED        (NB_SEED),
    .NB_TMR         (NB_TMR),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .RUN_CYCLES     (RUN_CYCLES),
    .UNLOCK_TIMEOUT (UNLOCK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_seed       (i_seed),
    .i_inject_en  (i_inject_en),
    .i_lock       (i_lock),
    .o_valid      (o_valid),
    .o_soft_reset (o_soft_reset),
    .o_seed       (o_seed),
    .o_corrupt    (o_corrupt),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_pass       (o_pass),
    .o_fail_code  (o_fail_code),
    .o_lock_lat   (o_lock_lat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_soft_reset === 1'b1) sr_cnt <= sr_cnt + 1;
    if (o_corrupt === 1'b1) cor_cnt <= cor_cnt + 1;
    if (o_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_test(input logic [7:0] seed, input logic inj);
    step();
    i_seed      = seed;
    i_inject_en = inj;
    i_start     = 1'b1;
    step();
    i_start     = 1'b0;
  endtask

  task automatic wait_corrupt(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (o_corrupt === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_corrupt_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    exp_t e;
    bit   found = 1'b0;
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (o_done === 1'b1) begin
        cycles = i;
        found  = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(found), 32'd1);
    if (found) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_has_entry"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check({tag, "_pass"}, 32'(o_pass), 32'(e.pass));
        check({tag, "_fail_code"}, 32'(o_fail_code), 32'(e.code));
        if (e.chk_lat) check({tag, "_lock_lat"}, 32'(o_lock_lat), 32'(e.lat));
        check({tag, "_pass_excl"}, 32'(o_pass && (o_fail_code != 2'd0)), 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_seed = '0; i_inject_en = 1'b0; i_lock = 1'b0;
    step();
    step();
    check("rst_outputs", {o_valid, o_soft_reset, o_seed, o_corrupt, o_busy, o_done, o_pass,
                          o_fail_code, o_lock_lat}, 32'd0);
    i_rst = 1'b0;
    step();

    // Nominal: lock after 5 ACQUIRE cycles, no injection.
    sr0 = sr_cnt;
    sb.push_back('{1'b1, 2'd0, 16'd5, 1'b1});
    start_test(8'h0A, 1'b0);
    check("seed_soft_reset", 32'(o_soft_reset), 32'd1);
    check("seed_valid", 32'(o_valid), 32'd0);
    check("seed_busy", 32'(o_busy), 32'd1);
    check("seed_value", 32'(o_seed), 32'h0A);
    step();
    check("acq_valid", 32'(o_valid), 32'd1);
    check("acq_soft_reset", 32'(o_soft_reset), 32'd0);
    repeat (5) step();
    i_lock = 1'b1;
    wait_done("nominal", RUN_CYCLES + 10, cyc);
    check("nominal_latency", 32'(cyc), 32'(RUN_CYCLES + 1));
    check("nominal_sr_pulses", 32'(sr_cnt - sr0), 32'd1);
    step();
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);
    step();
    step();
    check("pass_held", 32'(o_pass), 32'd1);
    check("seed_held", 32'(o_seed), 32'h0A);

    // Injection with the checker dropping lock 3 cycles after the corrupt pulse.
    cor0 = cor_cnt;
    sb.push_back('{1'b1, 2'd0, 16'd0, 1'b1});
    start_test(8'h5C, 1'b1);
    check("start_clears_pass", 32'(o_pass), 32'd0);
    wait_corrupt("inj_unlock", RUN_CYCLES + 20);
    repeat (3) step();
    i_lock = 1'b0;
    wait_done("inj_unlock", 10, cyc);
    check("inj_unlock_latency", 32'(cyc), 32'd1);
    check("inj_unlock_corrupts", 32'(cor_cnt - cor0), 32'd1);

    // Injection with lock stuck high.
    i_lock = 1'b1;
    cor0 = cor_cnt;
    sb.push_back('{1'b0, 2'd3, 16'd0, 1'b1});
    start_test(8'h33, 1'b1);
    wait_corrupt("inj_stuck", RUN_CYCLES + 20);
    wait_done("inj_stuck", UNLOCK_TIMEOUT + 10, cyc);
    check("inj_stuck_latency", 32'(cyc), 32'(UNLOCK_TIMEOUT + 1));
    check("inj_stuck_corrupts", 32'(cor_cnt - cor0), 32'd1);

    // Lock timeout.
    i_lock = 1'b0;
    i_inject_en = 1'b0;
    sb.push_back('{1'b0, 2'd1, 16'd0, 1'b0});
    start_test(8'h77, 1'b0);
    step();
    wait_done("timeout", LOCK_TIMEOUT + 10, cyc);
    check("timeout_latency", 32'(cyc), 32'(LOCK_TIMEOUT));

    // Lock lost at RUN cycle 100 with injection enabled: no INJECT.
    i_lock = 1'b1;
    cor0 = cor_cnt;
    sb.push_back('{1'b0, 2'd2, 16'd0, 1'b1});
    start_test(8'h21, 1'b1);
    step();
    step();
    repeat (100) step();
    i_lock = 1'b0;
    wait_done("lockloss", 5, cyc);
    i_lock = 1'b1;
    check("lockloss_latency", 32'(cyc), 32'd1);
    check("lockloss_no_inject", 32'(cor_cnt - cor0), 32'd0);

    // Zero seed substitution and start ignored while busy.
    i_lock = 1'b0;
    i_inject_en = 1'b0;
    sr0 = sr_cnt;
    sb.push_back('{1'b0, 2'd1, 16'd0, 1'b0});
    start_test(8'h00, 1'b0);
    check("zero_seed", 32'(o_seed), 32'h01);
    step();
    repeat (10) step();
    i_seed  = 8'h99;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_done("busy_start", LOCK_TIMEOUT, cyc);
    check("busy_start_latency", 32'(cyc), 32'(LOCK_TIMEOUT - 11));
    check("busy_start_sr_pulses", 32'(sr_cnt - sr0), 32'd1);
    check("busy_start_seed", 32'(o_seed), 32'h01);

    // Reset held 2 cycles in the middle of RUN aborts the test.
    i_lock = 1'b1;
    start_test(8'h0A, 1'b0);
    step();
    step();
    repeat (20) step();
    check("midrun_valid", 32'(o_valid), 32'd1);
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    check("midrun_rst_outputs", {o_valid, o_soft_reset, o_seed, o_corrupt, o_busy, o_done,
                                 o_pass, o_fail_code, o_lock_lat}, 32'd0);
    step();
    check("post_rst_idle", 32'({o_busy, o_done, o_valid}), 32'd0);
    repeat (5) step();
    check("done_pulse_count", 32'(done_cnt), 32'd6);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
